// File: rtl/display_producto_pkg.sv
// Shared definitions for the product display path.
//   - default widths for the product and the number of digits
//   - conversion engine state encoding
//   - active-low 7-segment codes, ordered {g,f,e,d,c,b,a}, and the nibble-to-segment map
package display_producto_pkg;

    localparam int W_PROD_DEF      = 16;
    localparam int NUM_DIG_DEF     = 5;
    localparam int REFRESH_DIV_DEF = 50000;

    typedef enum logic {
        REPOSO    = 1'b0,
        CONVIERTE = 1'b1
    } estado_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Non-decimal nibbles cannot come out of the converter, but they still
    // map to blank so the display never shows garbage.
    function automatic logic [6:0] nibble_a_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/display_producto_bin2bcd_secuencial.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
//
// State   | Meaning
// --------+---------------------------------------------------------
// REPOSO  | idle, waiting for carga
// CONVIERTE | shifting; one input bit consumed per cycle, W_BIN cycles
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   carga     - load strobe; restarts a conversion from any state
//   bin       - binary value captured on carga
//   bcd       - result of the current shift; valid as the final result while fin=1
//   ocupado   - conversion in progress
//   fin       - one-cycle strobe on the edge that performs the last shift
module bin2bcd_secuencial
    import display_producto_pkg::*;
#(
    parameter int W_BIN = W_PROD_DEF,
    parameter int N_DIG = NUM_DIG_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 carga,
    input  logic [W_BIN-1:0]     bin,
    output logic [4*N_DIG-1:0]   bcd,
    output logic                 ocupado,
    output logic                 fin
);

    localparam int CW = (W_BIN > 1) ? $clog2(W_BIN) : 1;

    estado_t               estado_q, estado_d;
    logic [W_BIN-1:0]      bin_q, bin_d;
    logic [4*N_DIG-1:0]    bcd_q, bcd_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [4*N_DIG-1:0]    ajustado;
    logic [4*N_DIG-1:0]    bcd_sh;
    logic [W_BIN-1:0]      bin_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= REPOSO;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        ajustado = bcd_q;
        for (int i = 0; i < N_DIG; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                ajustado[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        bcd_sh = {ajustado[4*N_DIG-2:0], bin_q[W_BIN-1]};
        bin_sh = {bin_q[W_BIN-2:0], 1'b0};
    end

    always_comb begin
        estado_d = estado_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        fin      = 1'b0;

        // A load always wins, even on the edge that would have finished:
        // the newest product replaces whatever was in flight.
        if (carga) begin
            estado_d = CONVIERTE;
            bin_d    = bin;
            bcd_d    = '0;
            cnt_d    = '0;
        end else if (estado_q == CONVIERTE) begin
            bcd_d = bcd_sh;
            bin_d = bin_sh;
            if (cnt_q == CW'(W_BIN-1)) begin
                estado_d = REPOSO;
                cnt_d    = '0;
                fin      = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // The top captures the result on the same edge as the last shift, so it
    // sees the shifted value rather than the register.
    assign bcd     = bcd_sh;
    assign ocupado = (estado_q == CONVIERTE);

endmodule

// File: rtl/display_producto.sv
// Product display stage: converts the multiplier result to decimal and
// drives a multiplexed common-anode 7-segment display with leading-zero blanking.
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   em         - load strobe from the multiplier FSM (producto valid while high)
//   producto   - unsigned product
//   ocupado    - conversion in progress
//   listo      - the display holds a valid converted value
//   anodos     - digit enables, active-low, bit 0 = least significant digit
//   segmentos  - {g,f,e,d,c,b,a}, active-low
module display_producto
    import display_producto_pkg::*;
#(
    parameter int W_PROD      = W_PROD_DEF,
    parameter int NUM_DIG     = NUM_DIG_DEF,
    parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                em,
    input  logic [W_PROD-1:0]   producto,
    output logic                ocupado,
    output logic                listo,
    output logic [NUM_DIG-1:0]  anodos,
    output logic [6:0]          segmentos
);

    localparam int SCW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW  = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    logic [4*NUM_DIG-1:0] bcd_res;
    logic                 fin;

    logic [4*NUM_DIG-1:0] disp_q, disp_d;
    logic                 listo_q, listo_d;
    logic [SCW-1:0]       scan_q, scan_d;
    logic [DW-1:0]        dig_q, dig_d;
    logic [NUM_DIG-1:0]   anodos_q, anodos_d;
    logic [6:0]           seg_q, seg_d;

    logic [NUM_DIG-1:0]   visible;
    logic                 hay_nz;
    logic [3:0]           sel_nib;
    logic                 sel_vis;

    bin2bcd_secuencial #(
        .W_BIN (W_PROD),
        .N_DIG (NUM_DIG)
    ) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .carga   (em),
        .bin     (producto),
        .bcd     (bcd_res),
        .ocupado (ocupado),
        .fin     (fin)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q   <= '0;
            listo_q  <= 1'b0;
            scan_q   <= '0;
            dig_q    <= '0;
            anodos_q <= '1;
            seg_q    <= SEG_BLANK;
        end else begin
            disp_q   <= disp_d;
            listo_q  <= listo_d;
            scan_q   <= scan_d;
            dig_q    <= dig_d;
            anodos_q <= anodos_d;
            seg_q    <= seg_d;
        end
    end

    // Display register: old value is held until a conversion actually finishes.
    always_comb begin
        disp_d  = fin ? bcd_res : disp_q;
        listo_d = listo_q | fin;
    end

    always_comb begin
        scan_d = scan_q;
        dig_d  = dig_q;
        if (scan_q == SCW'(REFRESH_DIV-1)) begin
            scan_d = '0;
            dig_d  = (dig_q == DW'(NUM_DIG-1)) ? '0 : dig_q + 1'b1;
        end else begin
            scan_d = scan_q + 1'b1;
        end
    end

    // A digit is visible if it or any more significant digit is nonzero;
    // digit 0 is always visible so zero reads as "0".
    always_comb begin
        hay_nz  = 1'b0;
        visible = '0;
        for (int i = NUM_DIG-1; i >= 0; i--) begin
            hay_nz     = hay_nz | (disp_d[i*4 +: 4] != 4'd0);
            visible[i] = hay_nz | (i == 0);
        end
    end

    always_comb begin
        sel_nib = '0;
        sel_vis = 1'b0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (dig_d == DW'(i)) begin
                sel_nib = disp_d[i*4 +: 4];
                sel_vis = visible[i];
            end
        end
    end

    // Outputs are built from next-state values and registered, so anode and
    // segment lines change together on one edge with no inter-digit glitch.
    always_comb begin
        anodos_d = '1;
        seg_d    = SEG_BLANK;
        if (listo_d) begin
            anodos_d = ~(NUM_DIG'(1) << dig_d);
            if (sel_vis) begin
                seg_d = nibble_a_seg(sel_nib);
            end
        end
    end

    assign listo     = listo_q;
    assign anodos    = anodos_q;
    assign segmentos = seg_q;

endmodule

// File: tb/tb_display_producto.sv
module tb_display_producto;

    localparam int W  = 16;
    localparam int ND = 5;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          em;
    logic [W-1:0]  producto;
    logic          ocupado;
    logic          listo;
    logic [ND-1:0] anodos;
    logic [6:0]    segmentos;

    display_producto #(
        .W_PROD      (W),
        .NUM_DIG     (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .em        (em),
        .producto  (producto),
        .ocupado   (ocupado),
        .listo     (listo),
        .anodos    (anodos),
        .segmentos (segmentos)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: time measured in clock edges since reset release,
    // conversion completes a fixed W edges after the latest load.
    int edges;
    int m_val;
    bit m_listo;
    bit m_busy;
    int m_done;
    int m_prod;

    logic [6:0] seg_tab [10];

    function automatic logic [6:0] exp_seg(int val, int d);
        int p;
        p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        if (d > 0 && val < p) return 7'b1111111;
        return seg_tab[(val / p) % 10];
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h (edge %0d)", tag, got, exp, edges);
        end
    endtask

    task automatic model_reset();
        edges   = 0;
        m_val   = 0;
        m_listo = 0;
        m_busy  = 0;
        m_done  = 0;
        m_prod  = 0;
    endtask

    task automatic step();
        int d;
        logic [ND-1:0] ea;
        logic [6:0]    es;
        @(posedge clk);
        edges++;
        if (em) begin
            m_prod = int'(producto);
            m_done = edges + W;
            m_busy = 1;
        end else if (m_busy && edges == m_done) begin
            m_val   = m_prod;
            m_listo = 1;
            m_busy  = 0;
        end
        #1;
        d  = (edges / RD) % ND;
        ea = '1;
        es = 7'b1111111;
        if (m_listo) begin
            ea[d] = 1'b0;
            es    = exp_seg(m_val, d);
        end
        chk("ocupado",   ocupado,   m_busy);
        chk("listo",     listo,     m_listo);
        chk("anodos",    anodos,    ea);
        chk("segmentos", segmentos, es);
    endtask

    task automatic run(int k);
        repeat (k) step();
    endtask

    task automatic pulse(int p);
        em       = 1'b1;
        producto = W'(p);
        step();
        em       = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_ocupado",   ocupado,   0);
        chk("rst_listo",     listo,     0);
        chk("rst_anodos",    anodos,    5'b11111);
        chk("rst_segmentos", segmentos, 7'b1111111);
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;

        rst = 1'b1;
        em = 1'b0;
        producto = '0;
        model_reset();
        #2;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run(3);

        // zero
        pulse(0);
        run(40);

        // maximum 255*255
        pulse(16'hFE01);
        run(45);

        // leading-zero blanking
        pulse(100);
        run(40);

        // restart: latest load wins
        pulse(7);
        run(2);
        pulse(16'h0309);
        run(40);

        // asynchronous reset mid-conversion, away from a clock edge
        pulse(16'h1234);
        run(8);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run(2);
        pulse(16'h1234);
        run(40);

        // back-to-back single-cycle strobes from the multiplier FSM
        pulse(12 * 13);
        run(20);
        pulse(3 * 3);
        run(40);

        // em held for several edges with a changing product
        em = 1'b1;
        producto = 16'd4321;
        step();
        producto = 16'd98;
        step();
        producto = 16'd50005;
        step();
        em = 1'b0;
        run(40);

        // randomized products and gaps (short gaps exercise restarts)
        repeat (10) begin
            pulse(int'($urandom_range(0, 65535)));
            run(int'($urandom_range(1, 30)));
        end
        run(45);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_producto.md
Name: display_producto

Overview:
- Output stage downstream of the multiplier control FSM; consumes the 16-bit product when the FSM's EM strobe (print state) fires.
- Converts the product to BCD with a sequential shift-add-3 (double-dabble) engine.
- Drives a multiplexed, active-low, common-anode 7-segment display with leading-zero blanking.

Parameters:
- W_PROD, 16, product width in bits (8x8 multiplier).
- NUM_DIG, 5, number of decimal digits/anodes (65025 max needs 5).
- REFRESH_DIV, 50000, clk cycles each digit stays lit (100 MHz -> 2 kHz per digit).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- em  in  1  load strobe from multiplier FSM; product valid while high.
- producto  in  W_PROD  unsigned product from the datapath.
- ocupado  out  1  conversion in progress.
- listo  out  1  display holds a valid converted value.
- anodos  out  NUM_DIG  digit enables, active-low, bit 0 = least significant digit.
- segmentos  out  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (async, immediate): ocupado=0, listo=0, anodos=all 1, segmentos=7'b1111111, BCD/display registers=0, scan counter=0, digit index=0, state=REPOSO.
- Engine FSM states: REPOSO, CONVIERTE.
- REPOSO: em=1 at an edge -> load producto into shift register, clear BCD accumulator, clear iteration counter, go to CONVIERTE, ocupado=1.
- CONVIERTE: each cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left 1 bit. Iteration counter counts 0..W_PROD-1.
- Final (W_PROD-th) shift edge: write the result to the display register, set listo=1, clear ocupado, return to REPOSO.
- Latency: ocupado is high for exactly W_PROD cycles after the load edge. The new value is shown from load edge + W_PROD.
- em during CONVIERTE: restarts the conversion with the current producto (latest wins). ocupado stays high. The display keeps the old value until the restarted conversion completes.
- em held high for several cycles: each sampled edge restarts. Completion occurs W_PROD cycles after the last em edge.
- Reset mid-conversion: aborts the conversion and returns everything to reset values. The display blanks.
- Scan counter: counts 0..REFRESH_DIV-1. On wrap, digit index advances 0..NUM_DIG-1 and wraps to 0.
- Exactly one anode is low at a time, and only when listo=1. With listo=0 all anodes stay 1.
- Anode and segment outputs are registered, with no glitching between digits.
- Leading-zero blanking: digits above the most significant nonzero digit output 1111111. Digit 0 is always shown, so a value of 0 displays "0".
- Segment codes 0-9 (gfedcba, active-low): 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Any other nibble: 1111111.
- BCD width is 4*NUM_DIG. The maximum 2^W_PROD-1 must fit; NUM_DIG=5 covers W_PROD=16.

Decomposition:
- Shared package holds:
  - W_PROD and NUM_DIG defaults.
  - Engine state encodings REPOSO and CONVIERTE.
  - 7-segment code constants and the blank code.
  - A function mapping a BCD nibble to a segment pattern.
- Sub-module bin2bcd_secuencial: the double-dabble engine with ports clk, rst, carga, bin, bcd, ocupado, fin.
- The top level owns the display register, scan counter, blanking logic and output registers.

Test Plan:
- Use REFRESH_DIV=4 throughout.
- Zero: pulse em with producto=0x0000.
  - ocupado high 16 cycles, then listo=1.
  - anodos cycles 11110 with segmentos=1000000.
  - All other digit slots show 1111111.
- Maximum: producto=0xFE01 (255*255=65025).
  - Digits 4..0 show 6,5,0,2,5 in order (0000010, 0010010, 1000000, 0100100, 0010010).
  - Each digit is held 4 cycles and the index wraps 4->0.
- Blanking: producto=0x0064 (100).
  - Digit 0 and digit 1 show 1000000, digit 2 shows 1111001.
  - Digits 3 and 4 are blank.
- Restart: em with 0x0007, then em with 0x0309 (777) three cycles later.
  - Display shows 777, not 7.
  - ocupado high continuously until 16 cycles after the second em.
- Reset mid-operation: assert rst asynchronously 8 cycles into a conversion of 0x1234, away from a clock edge.
  - Immediately ocupado=0, listo=0, anodos=11111, segmentos=1111111.
  - A following em with 0x1234 shows 4660.
- Back-to-back from FSM: drive em as a one-cycle pulse per multiplication (12*13=156, then 3*3=9).
  - Display updates to 156, then to 9.
  - listo stays 1 across the second conversion.
